// File: rtl/countdown_timer.sv
// Loadable down-counter with IDLE/RUN/DONE sequencing and a one-cycle
// terminal-count pulse. Synchronous active-high reset.
// Build option: define AUTO_RELOAD_EN to make the counter periodic. It then
// reloads from the last loaded value after reaching 0, instead of stopping in DONE.
module countdown_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_h,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] reload;

  // State, counter, reload register and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= ZERO;
      reload <= ZERO;
      busy   <= 1'b0;
      done   <= 1'b0;
      tc     <= 1'b0;
    end else if (load) begin
      count  <= load_h;
      reload <= load_h;
      tc     <= 1'b0;
      if (load_h != ZERO) begin
        state <= RUN;
        busy  <= 1'b1;
        done  <= 1'b0;
      end else begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end else begin
      tc <= 1'b0;
      case (state)
        RUN: begin
          if (en) begin
            if (count > ONE) begin
              count <= count - ONE;
            end else if (count == ONE) begin
              count <= ZERO;
              tc    <= 1'b1;
`ifdef AUTO_RELOAD_EN
              // stay in RUN; the next enabled edge restarts the period
`else
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
`endif
            end else begin
`ifdef AUTO_RELOAD_EN
              count <= reload;
`else
              // a zero count in RUN cannot occur here; park safely in DONE
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
`endif
            end
          end
        end
        IDLE, DONE: begin
          // count held, en ignored
        end
        default: begin
          state <= IDLE;
          count <= ZERO;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer (WIDTH=4): directed sequences plus
// random stimulus, checked against a behavioural timer model.
`timescale 1ns/1ps
module tb_countdown_timer;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_h = '0;
  logic         en = 1'b0;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic         tc;

  typedef struct packed {
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         tc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // behavioural model: value shown, last loaded value, running / finished flags
  int m_value    = 0;
  int m_period   = 0;
  bit m_running  = 1'b0;
  bit m_finished = 1'b0;
  bit m_tc       = 1'b0;

  countdown_timer #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .load_h (load_h),
    .en     (en),
    .count  (count),
    .busy   (busy),
    .done   (done),
    .tc     (tc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // advance the model by one clock edge given the inputs seen at that edge
  task automatic model_edge(input bit r, input bit l, input int lh, input bit e);
    m_tc = 1'b0;
    if (r) begin
      m_value = 0; m_period = 0; m_running = 1'b0; m_finished = 1'b0;
    end else if (l) begin
      m_value    = lh;
      m_period   = lh;
      m_running  = (lh != 0);
      m_finished = (lh == 0);
    end else if (m_running && e) begin
`ifdef AUTO_RELOAD_EN
      if (m_value == 0) m_value = m_period;
      else begin
        m_value = m_value - 1;
        m_tc    = (m_value == 0);
      end
`else
      m_value = m_value - 1;
      if (m_value == 0) begin
        m_tc       = 1'b1;
        m_running  = 1'b0;
        m_finished = 1'b1;
      end
`endif
    end
  endtask

  task automatic step(input bit r, input bit l, input int lh, input bit e);
    exp_t x;
    @(negedge clk);
    rst    = r;
    load   = l;
    load_h = W'(lh);
    en     = e;
    model_edge(r, l, lh, e);
    x.count = W'(m_value);
    x.busy  = m_running;
    x.done  = m_finished;
    x.tc    = m_tc;
    exp_q.push_back(x);
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL cycle %0d %s: got %0d, required %0d", cyc, name, got, want);
    end
  endtask

  // monitor: one expected entry per clock edge issued by the stimulus
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        cyc++;
        e = exp_q.pop_front();
        check("count", int'(count), int'(e.count));
        check("busy",  int'(busy),  int'(e.busy));
        check("done",  int'(done),  int'(e.done));
        check("tc",    int'(tc),    int'(e.tc));
      end
    end
  end

  initial begin
    // reset held two edges with a competing load
    step(1, 1, 5, 0);
    step(1, 1, 5, 0);

    // load 3, count down, then sit in the terminal state
    step(0, 1, 3, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);

    // pause with en low mid-count
    step(0, 1, 6, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(0, 0, 0, 1);

    // load overrides decrement
    step(0, 1, 6, 1);
    step(0, 0, 0, 1);
    step(0, 1, 9, 1);
    step(0, 0, 0, 1);

    // load held several cycles
    for (int i = 0; i < 3; i++) step(0, 1, 4, 1);

    // short period: 2,1,0,(2,1,0 with auto reload)
    step(0, 1, 2, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

    // load of zero goes straight to DONE
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);

    // reset mid-count with competing load
    step(0, 1, 7, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    step(1, 1, 7, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
           int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);

    @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter and load-value width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port load, input, 1 bit: level-sensitive load request, sampled each rising edge.
REQ-005 The block SHALL have port load_h, input, WIDTH bits: start value captured when load=1.
REQ-006 The block SHALL have port en, input, 1 bit: count enable; decrement allowed only when 1.
REQ-007 The block SHALL have port count, output, WIDTH bits: current counter value, registered.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in RUN, registered.
REQ-009 The block SHALL have port done, output, 1 bit: high while in DONE, registered.
REQ-010 The block SHALL have port tc, output, 1 bit: terminal-count pulse, registered, high for exactly the cycle in which count first shows 0 after a decrement.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, RUN, DONE; busy=(state==RUN), done=(state==DONE).
REQ-012 Priority at every edge SHALL be rst > load > en-decrement > hold.
REQ-013 On load=1 in any state, count SHALL take load_h on the next edge and load_h SHALL be stored in an internal reload register.
REQ-014 On load=1 with load_h!=0, state SHALL go to RUN; with load_h==0, state SHALL go to DONE, count 0, tc stays 0.
REQ-015 Load held high for several cycles SHALL reload count every cycle; no decrement occurs while load=1.
REQ-016 In RUN with en=1 and load=0, count SHALL decrement by exactly 1 per edge, with one-edge latency.
REQ-017 In RUN with en=0 and load=0, count and state SHALL hold unchanged.
REQ-018 In RUN with en=1 and count==1, the next edge SHALL set count=0 and tc=1; tc SHALL return to 0 on the following edge.
REQ-019 Count SHALL never wrap below 0; there is no decrement from 0 to all-ones.
REQ-020 In IDLE and DONE with load=0, count SHALL hold and en SHALL be ignored.
REQ-021 In DONE, count SHALL remain 0 until the next load or rst.

Reset
REQ-022 With rst=1 at a rising edge, the block SHALL set state=IDLE, count=0, busy=0, done=0, tc=0, and reload register=0, regardless of load or en.
REQ-023 A reset asserted mid-count SHALL abort the count with no tc pulse.

Configuration
REQ-024 Macro AUTO_RELOAD_EN SHALL select the terminal behaviour.
REQ-025 When AUTO_RELOAD_EN is undefined, the block SHALL go RUN->DONE on the edge that produces count=0 (REQ-018).
REQ-026 When AUTO_RELOAD_EN is defined, the block SHALL stay in RUN at count=0 and, on the next edge with en=1 and load=0, SHALL reload count from the reload register, giving a period of (reload value + 1) enabled cycles with one tc pulse per period.
REQ-027 When AUTO_RELOAD_EN is defined, DONE SHALL be reachable only via a load with load_h==0.

Verification (WIDTH=4)
REQ-028 The bench SHALL hold rst=1 for 2 edges with load=1 and load_h=5, and SHALL check count=0, busy=0, done=0, tc=0.
REQ-029 With no macro, the bench SHALL apply load=1 and load_h=3 for one cycle, then en=1, and SHALL check count 3,2,1,0 on successive edges, tc=1 only on the 0 cycle, then done=1 with count holding 0 for 5 edges.
REQ-030 The bench SHALL load 6, decrement to 4, drop en for 3 edges and check count=4 with busy=1, then raise en and check count=3.
REQ-031 The bench SHALL apply load=1 and load_h=9 with en=1 while count=5 and check count=9 on the next edge with no decrement.
REQ-032 With AUTO_RELOAD_EN, the bench SHALL load 2 with en=1 and check the count sequence 2,1,0,2,1,0 with tc every third edge, busy=1 throughout, and done=0.
REQ-033 The bench SHALL apply rst=1 at count=4 together with load=1 and load_h=7, and check count=0, state IDLE, and no tc pulse.
